// File: rtl/adf4351_spi_writer.sv
// ADF4351 3-wire register writer: shifts R5..R0 (full init) or R4,R0 (retune)
// MSB first with an LE pulse after each word; a START while busy is queued once.
module adf4351_spi_writer #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [31:0] R5_VAL  = 32'h00580005,
  parameter logic [31:0] R3_VAL  = 32'h000004B3,
  parameter logic [31:0] R2_VAL  = 32'h00004E42,
  parameter logic [31:0] R1_VAL  = 32'h08008011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        WR_ALL,
  input  logic [31:0] R0_IN,
  input  logic [31:0] R4_IN,
  output logic        ADF_CLK,
  output logic        ADF_DATA,
  output logic        ADF_LE,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIT_LO = 3'd1,
    BIT_HI = 3'd2,
    LATCH  = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [2:0]       word_q, word_d;
  logic [31:0]      r0_q, r0_d, r4_q, r4_d;
  logic             all_q, all_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d, data_q, data_d, le_q, le_d, busy_q, busy_d, done_q, done_d;
  logic             div_end_s;
  logic [2:0]       last_word_s;
  logic [31:0]      cur_word_s;

  // Transmission order: full init is R5,R4,R3,R2,R1,R0; retune is R4,R0.
  function automatic logic [31:0] word_sel(input logic [2:0] idx, input logic all,
                                           input logic [31:0] r0, input logic [31:0] r4);
    logic [31:0] w;
    if (all) begin
      case (idx)
        3'd0:    w = R5_VAL;
        3'd1:    w = r4;
        3'd2:    w = R3_VAL;
        3'd3:    w = R2_VAL;
        3'd4:    w = R1_VAL;
        default: w = r0;
      endcase
    end else begin
      case (idx)
        3'd0:    w = r4;
        default: w = r0;
      endcase
    end
    return w;
  endfunction

  assign div_end_s   = (div_q == DIV_LAST);
  assign last_word_s = all_q ? 3'd5 : 3'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= 5'd0;
      word_q    <= 3'd0;
      r0_q      <= 32'd0;
      r4_q      <= 32'd0;
      all_q     <= 1'b0;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      data_q    <= 1'b0;
      le_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      r0_q      <= r0_d;
      r4_q      <= r4_d;
      all_q     <= all_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      data_q    <= data_d;
      le_q      <= le_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    word_d    = word_q;
    r0_d      = r0_q;
    r4_d      = r4_q;
    all_d     = all_q;
    pending_d = pending_q;
    if (state_q != IDLE && START) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      IDLE: begin
        if (START || pending_q) begin
          state_d   = BIT_LO;
          div_d     = '0;
          bit_d     = 5'd31;
          word_d    = 3'd0;
          r0_d      = R0_IN;
          r4_d      = R4_IN;
          all_d     = WR_ALL;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BIT_LO: begin
        if (div_end_s) begin
          div_d   = '0;
          state_d = BIT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      BIT_HI: begin
        if (div_end_s) begin
          div_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            state_d = BIT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_end_s) begin
          div_d   = '0;
          state_d = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_end_s) begin
          div_d = '0;
          if (word_q != last_word_s) begin
            word_d  = word_q + 3'd1;
            bit_d   = 5'd31;
            state_d = BIT_LO;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so every pin comes straight from a flop.
  always_comb begin
    cur_word_s = word_sel(word_d, all_d, r0_d, r4_d);
    clk_d      = (state_d == BIT_HI);
    le_d       = (state_d == LATCH);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == GAP) && (state_d == IDLE);
    if (state_d == BIT_LO || state_d == BIT_HI) begin
      data_d = cur_word_s[bit_d];
    end else begin
      data_d = 1'b0;
    end
  end

  assign ADF_CLK  = clk_q;
  assign ADF_DATA = data_q;
  assign ADF_LE   = le_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_adf4351_spi_writer.sv
// Directed bench for adf4351_spi_writer: decodes the 3-wire stream back into words
// and checks order, LE/BUSY timing, START queuing, reset abort and a CLK_DIV=1 build.
module tb_adf4351_spi_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0, WR_ALL = 1'b0;
  logic        start1 = 1'b0, wr_all1 = 1'b0;
  logic [31:0] R0_IN = 32'd0, R4_IN = 32'd0;
  logic        ADF_CLK, ADF_DATA, ADF_LE, BUSY, DONE;
  logic        adf_clk1, adf_data1, adf_le1, busy1, done1;

  int n_total = 0, n_pass = 0;

  // decoded stream for the CLK_DIV=4 instance
  logic [31:0] shreg = 32'd0;
  logic [31:0] words[$];
  int          le_w[$], busy_w[$];
  int          le_cnt = 0, done_cnt = 0, viol = 0, last_idle = 0;
  int          le_run = 0, busy_run = 0, idle_run = 0;
  logic        p_clk = 1'b0, p_le = 1'b0, p_data = 1'b0, p_busy = 1'b0;
  // decoded stream for the CLK_DIV=1 instance
  logic [31:0] shreg1 = 32'd0;
  logic [31:0] words1[$];
  int          busy_w1[$];
  int          busy_run1 = 0;
  logic        p_clk1 = 1'b0, p_le1 = 1'b0, p_busy1 = 1'b0;

  adf4351_spi_writer dut (
    .CLK(CLK), .RST(RST), .START(START), .WR_ALL(WR_ALL), .R0_IN(R0_IN), .R4_IN(R4_IN),
    .ADF_CLK(ADF_CLK), .ADF_DATA(ADF_DATA), .ADF_LE(ADF_LE), .BUSY(BUSY), .DONE(DONE)
  );

  adf4351_spi_writer #(.CLK_DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(start1), .WR_ALL(wr_all1), .R0_IN(R0_IN), .R4_IN(R4_IN),
    .ADF_CLK(adf_clk1), .ADF_DATA(adf_data1), .ADF_LE(adf_le1), .BUSY(busy1), .DONE(done1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge CLK);
      if (DONE) seen++;
    end
    check({tag, "_done_seen"}, seen, n);
  endtask

  task automatic clear_mon();
    words.delete(); le_w.delete(); busy_w.delete();
    done_cnt = 0; le_cnt = 0;
  endtask

  task automatic check_words(input string tag, input logic [31:0] exp[$]);
    check({tag, "_nwords"}, words.size(), exp.size());
    for (int i = 0; i < exp.size() && i < words.size(); i++)
      check($sformatf("%s_w%0d", tag, i), words[i], exp[i]);
  endtask

  // Monitor: sample pins on the falling edge, away from the launching edge.
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      p_clk = 1'b0; p_le = 1'b0; p_data = 1'b0; p_busy = 1'b0;
      le_run = 0; busy_run = 0;
      p_clk1 = 1'b0; p_le1 = 1'b0; p_busy1 = 1'b0; busy_run1 = 0;
    end else begin
      if (ADF_CLK && !p_clk) shreg = {shreg[30:0], ADF_DATA};
      if (ADF_LE && !p_le) begin words.push_back(shreg); le_cnt++; end
      if (ADF_LE) le_run++;
      else if (p_le) begin le_w.push_back(le_run); le_run = 0; end
      if (((p_clk && ADF_CLK) || (p_le && ADF_LE)) && ADF_DATA != p_data) viol++;
      if (BUSY) begin
        if (!p_busy) last_idle = idle_run;
        busy_run++; idle_run = 0;
      end else begin
        if (p_busy) busy_w.push_back(busy_run);
        busy_run = 0; idle_run++;
      end
      if (DONE) done_cnt++;
      p_clk = ADF_CLK; p_le = ADF_LE; p_data = ADF_DATA; p_busy = BUSY;

      if (adf_clk1 && !p_clk1) shreg1 = {shreg1[30:0], adf_data1};
      if (adf_le1 && !p_le1) words1.push_back(shreg1);
      if (busy1) busy_run1++;
      else if (p_busy1) begin busy_w1.push_back(busy_run1); busy_run1 = 0; end
      p_clk1 = adf_clk1; p_le1 = adf_le1; p_busy1 = busy1;
    end
  end

  initial begin
    logic [31:0] full_exp[$];
    logic [31:0] exp_q[$];
    int le_base;

    full_exp = '{32'h00580005, 32'h00AC803C, 32'h000004B3, 32'h00004E42, 32'h08008011, 32'h00501F40};

    // reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs", {27'd0, ADF_CLK, ADF_DATA, ADF_LE, BUSY, DONE}, 32'd0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // full init
    WR_ALL = 1'b1; R4_IN = 32'h00AC803C; R0_IN = 32'h00501F40;
    clear_mon();
    pulse_start();
    wait_dones(1, 2000, "full");
    repeat (10) @(negedge CLK);
    check_words("full", full_exp);
    check("full_le_pulses", le_w.size(), 6);
    for (int i = 0; i < le_w.size(); i++) check($sformatf("full_le_width%0d", i), le_w[i], 4);
    check("full_busy_len", (busy_w.size() > 0) ? busy_w[0] : 0, 1584);
    check("full_done_cnt", done_cnt, 1);

    // fast retune
    WR_ALL = 1'b0; R4_IN = 32'h009C803C; R0_IN = 32'h00A00008;
    clear_mon();
    pulse_start();
    wait_dones(1, 1000, "retune");
    repeat (10) @(negedge CLK);
    exp_q = '{32'h009C803C, 32'h00A00008};
    check_words("retune", exp_q);
    check("retune_busy_len", (busy_w.size() > 0) ? busy_w[0] : 0, 528);

    // START while busy is queued; inputs changed mid-run affect only the relaunch
    clear_mon();
    pulse_start();
    repeat (48) @(negedge CLK);
    R0_IN = 32'h00640000;
    repeat (49) @(negedge CLK);
    pulse_start();
    repeat (8) @(negedge CLK);
    pulse_start();
    wait_dones(2, 2000, "queued");
    check("queued_idle_gap", last_idle, 1);
    repeat (700) @(negedge CLK);
    exp_q = '{32'h009C803C, 32'h00A00008, 32'h009C803C, 32'h00640000};
    check_words("queued", exp_q);
    check("queued_done_cnt", done_cnt, 2);

    // reset during the third word of a full init
    WR_ALL = 1'b1; R4_IN = 32'h00AC803C; R0_IN = 32'h00501F40;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 2000 && words.size() < 2; i++) @(negedge CLK);
    check("abort_reached_word3", words.size(), 2);
    repeat (100) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("abort_async_outputs", {27'd0, ADF_CLK, ADF_DATA, ADF_LE, BUSY, DONE}, 32'd0);
    le_base = le_cnt;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    repeat (400) @(negedge CLK);
    check("abort_no_le", le_cnt, le_base);
    check("abort_idle", {31'd0, BUSY}, 32'd0);
    clear_mon();
    pulse_start();
    wait_dones(1, 2000, "after_abort");
    repeat (10) @(negedge CLK);
    check_words("after_abort", full_exp);

    // CLK_DIV=1 instance
    @(negedge CLK); start1 = 1'b1; wr_all1 = 1'b1;
    @(negedge CLK); start1 = 1'b0;
    repeat (450) @(negedge CLK);
    check("div1_nwords", words1.size(), 6);
    for (int i = 0; i < 6 && i < words1.size(); i++)
      check($sformatf("div1_w%0d", i), words1[i], full_exp[i]);
    check("div1_busy_len", (busy_w1.size() > 0) ? busy_w1[0] : 0, 396);

    // START held high: back-to-back runs, then one queued run after release
    WR_ALL = 1'b0; R4_IN = 32'h009C803C; R0_IN = 32'h00A00008;
    clear_mon();
    @(negedge CLK); START = 1'b1;
    wait_dones(1, 1000, "held_a");
    wait_dones(1, 1000, "held_b");
    START = 1'b0;
    check("held_idle_gap", last_idle, 1);
    wait_dones(1, 1000, "held_c");
    repeat (700) @(negedge CLK);
    check("held_done_cnt", done_cnt, 3);
    check("held_nwords", words.size(), 6);
    check("data_stable", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adf4351_spi_writer.md
Name: adf4351_spi_writer

Overview:
- Serial programmer for the ADF4351 synthesizer.
- Takes the R0/R4 words produced by the frequency calculator, plus the static R1/R2/R3/R5 words held as parameters.
- Shifts them to the chip over the 3-wire interface (CLK/DATA/LE), MSB first, in datasheet order.
- Sits between the frequency calculator's R0/R4/DONE outputs and the ADF4351 pins. Supports a full init (R5..R0) and a fast retune (R4, R0 only).

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; minimum 1.
- R5_VAL, 32'h00580005: static R5 word.
- R3_VAL, 32'h000004B3: static R3 word.
- R2_VAL, 32'h00004E42: static R2 word.
- R1_VAL, 32'h08008011: static R1 word.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  request a write sequence; one-cycle pulse (typically the calculator's DONE).
- WR_ALL  in  1  1 = write R5,R4,R3,R2,R1,R0; 0 = write R4,R0 only.
- R0_IN  in  32  R0 word; sampled at launch.
- R4_IN  in  32  R4 word; sampled at launch.
- ADF_CLK  out  1  serial clock to the chip.
- ADF_DATA  out  1  serial data to the chip.
- ADF_LE  out  1  load enable to the chip.
- BUSY  out  1  high while a sequence is in progress.
- DONE  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Clock and reset: CLK; reset RST, asynchronous, active-low. All outputs are registered.
- Reset values: ADF_CLK=0, ADF_DATA=0, ADF_LE=0, BUSY=0, DONE=0, pending flag=0, state=IDLE.
- Reset mid-sequence: abort immediately and return to reset values. No LE pulse is issued for a partial word.
- States: IDLE, BIT_LO, BIT_HI, LATCH, GAP.
- IDLE:
  - If START=1 or pending=1, launch at the next edge.
  - At launch: latch R0_IN, R4_IN and WR_ALL into shadow registers; clear pending; set BUSY=1.
  - Word list: WR_ALL=1 gives R5,R4,R3,R2,R1,R0; WR_ALL=0 gives R4,R0.
  - Load bit 31 of the first word onto ADF_DATA; enter BIT_LO.
- BIT_LO (CLK_DIV cycles): ADF_CLK=0 and ADF_DATA holds the current bit. Then go to BIT_HI.
- BIT_HI (CLK_DIV cycles): ADF_CLK=1; the chip samples on this rising edge and DATA is stable throughout.
  - At the end of BIT_HI, ADF_CLK returns to 0.
  - If the bit index > 0: decrement the index, drive the next bit, enter BIT_LO.
  - Otherwise: enter LATCH.
- LATCH (CLK_DIV cycles): ADF_CLK=0, ADF_LE=1, ADF_DATA=0.
- GAP (CLK_DIV cycles): ADF_LE=0.
  - If more words remain: load bit 31 of the next word and enter BIT_LO.
  - Otherwise: return to IDLE with BUSY=0 and DONE=1 for one cycle, on the same edge.
- Timing: one word takes 66*CLK_DIV cycles. BUSY lasts 396*CLK_DIV cycles (WR_ALL=1) or 132*CLK_DIV cycles (WR_ALL=0).
- Counters: one divider counter (counts 0..CLK_DIV-1), a 5-bit bit index (31 down to 0), and a 3-bit word index.
- Words are transmitted verbatim. Control bits [2:0] are not checked.
- START while BUSY=1:
  - Sets pending; multiple STARTs collapse into one.
  - The running sequence is unaffected; its shadow registers are not updated.
  - The relaunch happens one cycle after DONE, resampling R0_IN/R4_IN/WR_ALL at that cycle.
- START in the DONE cycle: the block is already IDLE, so this is treated as a normal launch at the next edge.
- R0_IN/R4_IN changes while busy: no effect on the current sequence.

Test Plan:
- Reset, then START with WR_ALL=1, R4_IN=00AC803C, R0_IN=00501F40, CLK_DIV=4:
  - Six LE pulses, each 4 cycles high.
  - Words captured on ADF_CLK rising edges are 00580005, 00AC803C, 000004B3, 00004E42, 08008011, 00501F40.
  - BUSY high for 1584 cycles, then a single DONE pulse.
- START with WR_ALL=0, R4_IN=009C803C, R0_IN=00A00008:
  - Exactly two words captured, in order 009C803C then 00A00008.
  - BUSY 528 cycles.
- Second START at cycle 100 of a WR_ALL=0 run, with R0_IN changed to 00640000 at cycle 50:
  - The first run still sends the original R0.
  - DONE pulses, then BUSY reasserts on the next edge.
  - The second run sends R0=00640000.
  - Exactly two DONE pulses in total.
- RST low during the 3rd word of a WR_ALL=1 run:
  - All outputs go to 0 asynchronously and no further LE pulse occurs.
  - After release, a new START runs a full, correct sequence.
- CLK_DIV=1 build: each SCLK period is 2 cycles, WR_ALL=1 BUSY lasts 396 cycles, and data is correct.
- Data-stability check: ADF_DATA never changes while ADF_CLK=1 or ADF_LE=1. START held high continuously gives back-to-back sequences, each separated by a 1-cycle IDLE.
